// File: rtl/lc3_alu_seq.sv
// Multi-cycle LC-3 ALU: single-cycle ADD/AND/NOT plus iterative shifts and shift-add MUL
// on the reserved 4'b1101 opcode, with valid/ready handshakes on both sides.
module lc3_alu_seq #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instruction,
    input  logic [WIDTH-1:0] sr1,
    input  logic [WIDTH-1:0] sr2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       cc_nzp,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 16);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {EXT_SHL = 2'b00, EXT_SHR = 2'b01, EXT_SAR = 2'b10, EXT_MUL = 2'b11} ext_t;

    state_t           state, state_next;
    ext_t             funct, busy_op;
    logic [3:0]       opcode, k;
    logic [WIDTH-1:0] op2, quick_result, acc, acc_step, mcand, mplier;
    logic             quick_illegal, multi;
    logic [CW-1:0]    cnt;
    logic             unused_bits;

    // Register-number fields are decoded upstream; only the ALU-relevant bits are consumed here.
    assign unused_bits = ^instruction[11:6];

    assign opcode = instruction[15:12];
    assign funct  = ext_t'(instruction[5:4]);
    assign k      = instruction[3:0];
    assign op2    = instruction[5] ? {{(WIDTH-5){instruction[4]}}, instruction[4:0]} : sr2;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    function automatic logic [2:0] nzp(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v == '0, !v[WIDTH-1] && (v != '0)};
    endfunction

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        quick_result  = ~sr1;
        quick_illegal = 1'b1;
        multi         = 1'b0;
        case (opcode)
            4'b0001: begin quick_result = sr1 + op2; quick_illegal = 1'b0; end
            4'b0101: begin quick_result = sr1 & op2; quick_illegal = 1'b0; end
            4'b1001: begin quick_result = ~sr1;      quick_illegal = 1'b0; end
            4'b1101: begin
                quick_illegal = 1'b0;
                quick_result  = sr1;
                if (funct == EXT_MUL) begin
                    if (MUL_EN) begin
                        multi = 1'b1;
                    end else begin
                        quick_result  = '0;
                        quick_illegal = 1'b1;
                    end
                end else begin
                    multi = (k != 4'd0);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        acc_step = acc;
        case (busy_op)
            EXT_SHL: acc_step = acc << 1;
            EXT_SHR: acc_step = acc >> 1;
            EXT_SAR: acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
            EXT_MUL: acc_step = mplier[0] ? acc + mcand : acc;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = multi ? BUSY : DONE;
            BUSY:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            busy_op <= EXT_SHL;
            result  <= '0;
            cc_nzp  <= 3'b000;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (multi) begin
                        busy_op <= funct;
                        acc     <= (funct == EXT_MUL) ? '0 : sr1;
                        mcand   <= sr1;
                        mplier  <= sr2;
                        cnt     <= (funct == EXT_MUL) ? CW'(WIDTH) : CW'(k);
                        illegal <= 1'b0;
                    end else begin
                        result  <= quick_result;
                        cc_nzp  <= nzp(quick_result);
                        illegal <= quick_illegal;
                    end
                end
                BUSY: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    // The final iteration's value goes straight to the result register.
                    if (cnt == CW'(1)) begin
                        result <= acc_step;
                        cc_nzp <= nzp(acc_step);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
